// File: rtl/espi_cmd_queue_if.sv
// espi_cmd_queue_if: host request/response and eSPI master signals.
// slave = queue side, master = host + eSPI master model side.
interface espi_cmd_queue_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_cmd;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_cmd;
  logic [7:0] rsp_rdata;
  logic       rsp_timeout;
  logic       start_transaction;
  logic [7:0] command;
  logic [7:0] write_data;
  logic [7:0] read_data;
  logic       transaction_done;
  logic       busy;

  modport slave (
    input  req_valid,
    input  req_cmd,
    input  req_wdata,
    input  rsp_ready,
    input  read_data,
    input  transaction_done,
    output req_ready,
    output rsp_valid,
    output rsp_cmd,
    output rsp_rdata,
    output rsp_timeout,
    output start_transaction,
    output command,
    output write_data,
    output busy
  );

  modport master (
    output req_valid,
    output req_cmd,
    output req_wdata,
    output rsp_ready,
    output read_data,
    output transaction_done,
    input  req_ready,
    input  rsp_valid,
    input  rsp_cmd,
    input  rsp_rdata,
    input  rsp_timeout,
    input  start_transaction,
    input  command,
    input  write_data,
    input  busy
  );
endinterface

// File: rtl/espi_cmd_queue.sv
// espi_cmd_queue: request FIFO -> one-at-a-time eSPI sequencer -> response FIFO.
// Optional WAIT watchdog enabled by defining ESPI_CMDQ_TIMEOUT_EN.
module espi_cmd_queue #(
  parameter int REQ_DEPTH      = 4,
  parameter int RSP_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic           clk,
  input logic           reset_n,
  espi_cmd_queue_if.slave bus
);
  localparam int QA = $clog2(REQ_DEPTH);
  localparam int SA = $clog2(RSP_DEPTH);

  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] wdata;
  } req_t;

  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] rdata;
    logic       to;
  } rsp_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE
  } state_t;

  state_t     state;
  logic       start_q;
  logic [7:0] cmd_q;
  logic [7:0] wdata_q;
  logic       busy_q;
  logic       done_q;
  logic       to_q;
  logic       done_rise;
  logic       timeout_hit;

  req_t       req_mem [REQ_DEPTH];
  logic [QA:0] req_wp;
  logic [QA:0] req_rp;
  logic       req_full;
  logic       req_empty;
  logic       req_push;
  logic       req_pop;
  req_t       req_head;

  rsp_t       rsp_mem [RSP_DEPTH];
  logic [SA:0] rsp_wp;
  logic [SA:0] rsp_rp;
  logic       rsp_full;
  logic       rsp_empty;
  logic       rsp_push;
  logic       rsp_pop;
  rsp_t       rsp_head;
  rsp_t       rsp_in;

  assign req_full  = (req_wp[QA] != req_rp[QA]) &&
                     (req_wp[QA-1:0] == req_rp[QA-1:0]);
  assign req_empty = (req_wp == req_rp);
  assign req_push  = bus.req_valid && !req_full;
  assign req_pop   = (state == CAPTURE);
  assign req_head  = req_mem[req_rp[QA-1:0]];

  assign rsp_full  = (rsp_wp[SA] != rsp_rp[SA]) &&
                     (rsp_wp[SA-1:0] == rsp_rp[SA-1:0]);
  assign rsp_empty = (rsp_wp == rsp_rp);
  assign rsp_push  = (state == CAPTURE);
  assign rsp_pop   = !rsp_empty && bus.rsp_ready;
  assign rsp_head  = rsp_mem[rsp_rp[SA-1:0]];

  assign rsp_in.cmd   = cmd_q;
  assign rsp_in.rdata = to_q ? 8'h00 : bus.read_data;
  assign rsp_in.to    = to_q;

  // A stale high done is masked by done_q being forced high in ISSUE
  assign done_rise = bus.transaction_done && !done_q;

`ifdef ESPI_CMDQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wd_cnt;

  assign timeout_hit = (state == WAIT) &&
                       (wd_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Watchdog: cleared on the way into WAIT, counts WAIT cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
    end else if (state == ISSUE) begin
      wd_cnt <= '0;
    end else if (state == WAIT) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  // Watchdog compiled out: this compare is constant false
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  // Request storage, written on accepted host pushes
  always_ff @(posedge clk) begin
    if (req_push) begin
      req_mem[req_wp[QA-1:0]] <= '{cmd: bus.req_cmd,
                                   wdata: bus.req_wdata};
    end
  end

  // Request pointers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_wp <= '0;
      req_rp <= '0;
    end else begin
      if (req_push) req_wp <= req_wp + 1'b1;
      if (req_pop)  req_rp <= req_rp + 1'b1;
    end
  end

  // Response storage, written in CAPTURE
  always_ff @(posedge clk) begin
    if (rsp_push) begin
      rsp_mem[rsp_wp[SA-1:0]] <= rsp_in;
    end
  end

  // Response pointers; push and pop may share a cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_wp <= '0;
      rsp_rp <= '0;
    end else begin
      if (rsp_push) rsp_wp <= rsp_wp + 1'b1;
      if (rsp_pop)  rsp_rp <= rsp_rp + 1'b1;
    end
  end

  // Sequencer: one outstanding transaction, all outputs registered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      start_q <= 1'b0;
      cmd_q   <= 8'h00;
      wdata_q <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_q  <= bus.transaction_done;
      unique case (state)
        IDLE: begin
          if (!req_empty && !rsp_full) begin
            state   <= ISSUE;
            start_q <= 1'b1;
            cmd_q   <= req_head.cmd;
            wdata_q <= req_head.wdata;
            busy_q  <= 1'b1;
          end
        end
        ISSUE: begin
          state  <= WAIT;
          done_q <= 1'b1;
        end
        WAIT: begin
          if (done_rise) begin
            state <= CAPTURE;
            to_q  <= 1'b0;
          end else if (timeout_hit) begin
            state <= CAPTURE;
            to_q  <= 1'b1;
          end
        end
        CAPTURE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready         = !req_full;
  assign bus.rsp_valid         = !rsp_empty;
  assign bus.rsp_cmd           = rsp_empty ? 8'h00 : rsp_head.cmd;
  assign bus.rsp_rdata         = rsp_empty ? 8'h00 : rsp_head.rdata;
  assign bus.rsp_timeout       = !rsp_empty && rsp_head.to;
  assign bus.start_transaction = start_q;
  assign bus.command           = cmd_q;
  assign bus.write_data        = wdata_q;
  assign bus.busy              = busy_q;
endmodule

// File: tb/tb_espi_cmd_queue.sv
// tb_espi_cmd_queue: directed + random checks against queue-based model.
// Timeout steps run when ESPI_CMDQ_TIMEOUT_EN is defined.
module tb_espi_cmd_queue;
  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  espi_cmd_queue_if bus();

  espi_cmd_queue #(
    .REQ_DEPTH(4),
    .RSP_DEPTH(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  typedef struct {
    logic [7:0] c;
    logic [7:0] w;
  } req_s;

  typedef struct {
    logic [7:0] c;
    logic [7:0] d;
    logic       t;
  } rsp_s;

  req_s req_q[$];
  rsp_s exp_q[$];

  int total = 0;
  int bad = 0;
  int start_cnt = 0;

  bit auto_m = 1'b0;
  bit level_m = 1'b0;
  logic       a_done = 1'b0;
  logic [7:0] a_rd = 8'h00;
  logic       m_done = 1'b0;
  logic [7:0] m_rd = 8'h00;

  assign bus.transaction_done = auto_m ? a_done : m_done;
  assign bus.read_data        = auto_m ? a_rd : m_rd;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp();
    rsp_s e;
    chk("rsp_exp_avail", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("rsp_cmd", bus.rsp_cmd, e.c);
      chk("rsp_rdata", bus.rsp_rdata, e.d);
      chk("rsp_timeout", bus.rsp_timeout, e.t);
    end
  endtask

  task automatic push(input logic [7:0] c, input logic [7:0] w);
    int n = 0;
    bit ok = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_cmd   = c;
    bus.req_wdata = w;
    while (!ok && n <= 200) begin
      @(negedge clk);
      if (bus.req_ready) ok = 1'b1;
      else n++;
    end
    chk("push_acc", ok, 1);
    if (ok) req_q.push_back('{c, w});
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain(input int n, input int bound);
    int got = 0;
    int cyc = 0;
    bus.rsp_ready = 1'b1;
    while (got < n && cyc < bound) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        chk_rsp();
        got++;
      end
      cyc++;
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    chk("drain_cnt", got, n);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // eSPI master model and start-pulse monitor
  initial begin
    int cnt;
    bit outst;
    logic [7:0] cur;
    req_s r;
    cnt = 0;
    outst = 1'b0;
    cur = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        outst = 1'b0;
        cnt = 0;
        a_done = 1'b0;
        continue;
      end
      if (bus.start_transaction) begin
        start_cnt++;
        chk("start_exp_avail", req_q.size() != 0, 1);
        if (req_q.size() != 0) begin
          r = req_q.pop_front();
          chk("start_cmd", bus.command, r.c);
          chk("start_wdata", bus.write_data, r.w);
        end
        if (auto_m) begin
          chk("start_overlap", outst, 0);
          outst = 1'b1;
          cnt = $urandom_range(2, 6);
          cur = bus.command;
        end
      end else if (auto_m && outst) begin
        cnt--;
        if (cnt == 1) a_done = 1'b0;
        if (cnt == 0) begin
          a_done = 1'b1;
          a_rd = 8'($urandom);
          exp_q.push_back('{cur, a_rd, 1'b0});
          outst = 1'b0;
        end
      end else if (auto_m && !level_m) begin
        a_done = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int s0;
    int pushed;
    int popped;
    int k;
    bus.req_valid = 1'b0;
    bus.req_cmd   = 8'h00;
    bus.req_wdata = 8'h00;
    bus.rsp_ready = 1'b0;

    // reset values
    #1;
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_start", bus.start_transaction, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_command", bus.command, 0);
    chk("rst_wdata", bus.write_data, 0);
    chk("rst_rsp_cmd", bus.rsp_cmd, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_to", bus.rsp_timeout, 0);
    #22;
    reset_n = 1'b1;
    step();

    // single request, manual master
    push(8'h01, 8'hAA);
    step();
    chk("single_start", bus.start_transaction, 1);
    chk("single_cmd", bus.command, 8'h01);
    chk("single_wd", bus.write_data, 8'hAA);
    chk("single_busy", bus.busy, 1);
    step();
    chk("single_wait_start", bus.start_transaction, 0);
    chk("single_wait_busy", bus.busy, 1);
    step();
    m_rd = 8'h5C;
    m_done = 1'b1;
    step();
    chk("single_capt_valid", bus.rsp_valid, 0);
    m_done = 1'b0;
    step();
    chk("single_rsp_valid", bus.rsp_valid, 1);
    chk("single_idle_busy", bus.busy, 0);
    exp_q.push_back('{8'h01, 8'h5C, 1'b0});
    drain(1, 5);
    chk("single_starts", start_cnt, 1);

    // back-to-back, auto master with pulsed done
    auto_m = 1'b1;
    level_m = 1'b0;
    s0 = start_cnt;
    for (int i = 0; i < 4; i++) push(8'(8'h10 + i), 8'(8'hB0 + i));
    chk("b2b_full", bus.req_ready, 0);
    drain(4, 200);
    chk("b2b_starts", start_cnt - s0, 4);

    // response backpressure, level done
    level_m = 1'b1;
    s0 = start_cnt;
    for (int i = 0; i < 6; i++) push(8'(8'h60 + i), 8'(8'hC0 + i));
    repeat (60) step();
    chk("bp_starts", start_cnt - s0, 4);
    chk("bp_busy", bus.busy, 0);
    chk("bp_rsp_valid", bus.rsp_valid, 1);
    chk("bp_req_ready", bus.req_ready, 1);
    drain(6, 400);
    chk("bp_starts_all", start_cnt - s0, 6);

    // random traffic
    level_m = 1'($urandom);
    s0 = start_cnt;
    pushed = 0;
    popped = 0;
    repeat (400) begin
      bus.req_valid = ($urandom_range(0, 3) != 0);
      bus.req_cmd   = 8'($urandom);
      bus.req_wdata = 8'($urandom);
      bus.rsp_ready = 1'($urandom);
      @(negedge clk);
      if (bus.req_valid && bus.req_ready) begin
        req_q.push_back('{bus.req_cmd, bus.req_wdata});
        pushed++;
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        chk_rsp();
        popped++;
      end
      step();
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    drain(pushed - popped, 2000);
    chk("rand_starts", start_cnt - s0, pushed);
    repeat (12) step();

    // sticky done across transactions, manual master
    auto_m = 1'b0;
    m_done = 1'b0;
    push(8'h20, 8'h21);
    step();
    chk("sticky0_start", bus.start_transaction, 1);
    step();
    step();
    m_rd = 8'h77;
    m_done = 1'b1;
    step();
    step();
    chk("sticky0_valid", bus.rsp_valid, 1);
    exp_q.push_back('{8'h20, 8'h77, 1'b0});
    drain(1, 5);
    push(8'h22, 8'h23);
    step();
    chk("sticky1_start", bus.start_transaction, 1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("sticky1_busy", bus.busy, 1);
      chk("sticky1_nocapt", bus.rsp_valid, 0);
    end
    m_done = 1'b0;
    step();
    m_done = 1'b1;
    m_rd = 8'h99;
    step();
    chk("sticky1_capt", bus.rsp_valid, 0);
    step();
    chk("sticky1_valid", bus.rsp_valid, 1);
    exp_q.push_back('{8'h22, 8'h99, 1'b0});
    drain(1, 5);
    m_done = 1'b0;

`ifdef ESPI_CMDQ_TIMEOUT_EN
    // watchdog, master never completes
    push(8'h50, 8'h51);
    push(8'h52, 8'h53);
    chk("to_start", bus.start_transaction, 1);
    k = 0;
    while (!bus.rsp_valid && k < 40) begin
      step();
      k++;
    end
    chk("to_latency", k, 18);
    chk("to_cmd", bus.rsp_cmd, 8'h50);
    chk("to_rdata", bus.rsp_rdata, 8'h00);
    chk("to_flag", bus.rsp_timeout, 1);
    step();
    chk("to_next_start", bus.start_transaction, 1);
    chk("to_next_cmd", bus.command, 8'h52);
    exp_q.push_back('{8'h50, 8'h00, 1'b1});
    exp_q.push_back('{8'h52, 8'h00, 1'b1});
    drain(2, 80);
`else
    k = 0;
`endif

    // asynchronous reset in the middle of WAIT
    push(8'h40, 8'h41);
    step();
    chk("rstw_start", bus.start_transaction, 1);
    step();
    chk("rstw_busy", bus.busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rstw_async_busy", bus.busy, 0);
    chk("rstw_async_cmd", bus.command, 0);
    chk("rstw_async_wd", bus.write_data, 0);
    chk("rstw_async_rsp", bus.rsp_valid, 0);
    chk("rstw_async_ready", bus.req_ready, 1);
    req_q.delete();
    step();
    #3;
    reset_n = 1'b1;
    s0 = start_cnt;
    repeat (6) step();
    chk("rstw_no_start", start_cnt - s0, 0);
    chk("rstw_rsp_valid", bus.rsp_valid, 0);
    chk("rstw_req_ready", bus.req_ready, 1);
    chk("rstw_busy_after", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/espi_cmd_queue.md
# espi_cmd_queue

Transaction queue feeding the eSPI master. It buffers host-issued command/write-data pairs in a request FIFO and sequences them one at a time onto the master's `start_transaction` / `command` / `write_data` inputs. It waits for the master's `transaction_done` and captures `read_data` into a response FIFO. It sits between the host/register side and the eSPI master, so the host never has to track master busy state.

## Interface
Parameters:
- `REQ_DEPTH`, 4 — request FIFO entries; power of 2, ≥2.
- `RSP_DEPTH`, 4 — response FIFO entries; power of 2, ≥2.
- `TIMEOUT_CYCLES`, 1024 — watchdog limit in WAIT; only used with the macro in Configuration.

Ports:
- `clk`  in  1  single clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  host request valid.
- `req_ready`  out  1  request FIFO not full.
- `req_cmd`  in  8  command byte.
- `req_wdata`  in  8  write data byte.
- `rsp_valid`  out  1  response FIFO not empty.
- `rsp_ready`  in  1  host consumes response.
- `rsp_cmd`  out  8  command the response belongs to.
- `rsp_rdata`  out  8  captured `read_data`.
- `rsp_timeout`  out  1  response was produced by the watchdog; `rsp_rdata` = 8'h00.
- `start_transaction`  out  1  one-cycle start pulse to the master.
- `command`  out  8  to master.
- `write_data`  out  8  to master.
- `read_data`  in  8  from master.
- `transaction_done`  in  1  from master; level or pulse.
- `busy`  out  1  FSM not in IDLE.

## Operation
- **Request FIFO:**
  - Push on `req_valid && req_ready`.
  - `req_ready = !req_full`. No push-when-full even with a same-cycle pop.
- **FSM states:** IDLE, ISSUE, WAIT, CAPTURE.
  - IDLE → ISSUE when the request FIFO is non-empty and the response FIFO is not full. This means a response can never be dropped.
  - ISSUE: `start_transaction` = 1 for exactly this cycle. `command`/`write_data` = FIFO head. Always → WAIT.
  - WAIT: → CAPTURE on a rising edge of `transaction_done`. The edge is detected from a registered copy `done_q`; `done_q` is forced to 1 on the ISSUE cycle, so a done that is still high from the previous transaction is ignored.
  - CAPTURE:
    - Push {head cmd, `read_data`, timeout = 0} into the response FIFO.
    - Pop the request FIFO.
    - → IDLE.
- `command`/`write_data` hold the head entry from ISSUE through CAPTURE. They are registered, and hold their last value otherwise.
- **Response FIFO:**
  - Pop on `rsp_valid && rsp_ready`.
  - A CAPTURE push and a host pop in the same cycle are both honoured.
- Pointers are log2(DEPTH)+1 bits; full/empty are derived from the MSB and wrap.

## Timing
- **Reset values:**
  - All outputs 0, with `req_ready` = 1.
  - FSM in IDLE; FIFOs empty; `done_q` = 0; watchdog counter = 0.
- **Latency:**
  - A request accepted at edge N into an empty queue (response FIFO not full, FSM idle) puts ISSUE in cycle N+1, i.e. `start_transaction` is high for cycle N+1.
  - The done edge detected at edge M gives CAPTURE in cycle M+1. The response is visible (`rsp_valid`) from cycle M+2.
  - The next ISSUE is no earlier than 1 cycle after CAPTURE.
- One transaction is outstanding at a time. `start_transaction` is never asserted while in WAIT.
- If the response FIFO is full, the FSM stalls in IDLE. `busy` = 0 and requests are still accepted until the request FIFO is full.
- A reset mid-transaction aborts immediately. Both FIFOs are cleared, and no response is produced for the in-flight request.

## Configuration
- Macro: `ESPI_CMDQ_TIMEOUT_EN`.
- **Defined:**
  - A counter runs in WAIT and clears on entering WAIT.
  - When it reaches `TIMEOUT_CYCLES`-1 with no done edge, the FSM goes to CAPTURE. It pushes {cmd, 8'h00, timeout = 1} and pops the request.
  - A done edge in the same cycle as the expiry wins, with timeout = 0.
- **Undefined:**
  - No counter; WAIT exits only on a done edge.
  - `rsp_timeout` is tied to 0 and the `TIMEOUT_CYCLES` parameter is unused.

## Test plan
- **Single request:** push cmd 8'h01 / wdata 8'hAA; the master model returns done with read_data 8'h5C. Expect:
  - exactly one `start_transaction` pulse carrying 8'h01/8'hAA;
  - one response {8'h01, 8'h5C, 0}.
- **Back-to-back:** push 4 requests (cmd 8'h10..8'h13) with the request FIFO full after 4 pushes. Expect:
  - `req_ready` = 0 after the 4th push;
  - 4 start pulses in order, never overlapping a WAIT;
  - responses returned in order.
- **Response backpressure:** hold `rsp_ready` = 0 and push 6 requests. Expect:
  - exactly 4 start pulses, after which the FSM stays in IDLE and `busy` = 0;
  - releasing `rsp_ready` drains the responses and resumes issuing the rest.
- **Sticky done:** `transaction_done` stays high from the previous transaction into ISSUE. Expect:
  - no premature CAPTURE;
  - completion only on the next low→high edge.
- **Timeout (macro defined, `TIMEOUT_CYCLES` = 16):** the master never completes. Expect:
  - a response {cmd, 8'h00, 1} 16 cycles after entering WAIT;
  - the next request is then issued.
- **Reset mid-WAIT:** assert `reset_n` = 0 asynchronously between clock edges. Expect:
  - all outputs at reset values immediately;
  - `rsp_valid` = 0 and `req_ready` = 1 after release.
